// File: rtl/stepper_pkg.sv
// -----------------------------------------------------------------------------
// stepper_pkg
// Shared types and constants for the stepper axis motion generator.
//   state_e    : controller states (IDLE, CALC, MOVE, JOG)
//   FRAC_BITS  : fractional bits of velocity / position accumulator
//   DIV_CYCLES : clocks the serial divider needs per move
//   HALF_STEP  : accumulator start value (half a step, rounds the step grid)
//   V_MAX      : largest velocity magnitude (just under one step per clock)
//   abs32      : two's-complement magnitude of a 32-bit value
// -----------------------------------------------------------------------------
package stepper_pkg;

  localparam int FRAC_BITS  = 31;
  localparam int DIV_CYCLES = 32;

  localparam logic [FRAC_BITS-1:0] HALF_STEP = {1'b1, {(FRAC_BITS-1){1'b0}}};
  localparam logic [FRAC_BITS-1:0] V_MAX     = {FRAC_BITS{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    MOVE = 2'd2,
    JOG  = 2'd3
  } state_e;

  function automatic logic [31:0] abs32(input logic [31:0] x);
    return x[31] ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/stepper_div.sv
// -----------------------------------------------------------------------------
// stepper_div
// Serial restoring unsigned divider, 63-bit dividend / 32-bit divisor,
// one quotient bit per clock over DIV_CYCLES clocks. The quotient is only
// meaningful when dividend[62:32] < divisor (the caller clamps otherwise).
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   start_i      : load operands and begin (may restart a running division)
//   dividend_i   : 63-bit unsigned dividend
//   divisor_i    : 32-bit unsigned divisor
//   busy_o       : high while iterations remain
//   quotient_o   : quotient, valid once busy_o falls
// -----------------------------------------------------------------------------
module stepper_div
  import stepper_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [62:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic        busy_o,
  output logic [31:0] quotient_o
);

  logic [31:0] rem_q, rem_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvs_q, dvs_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] trial_s;
  logic [32:0] diff_s;

  // Remainder stays below the divisor, so a negative trial shows up in bit 32.
  always_comb begin
    rem_d   = rem_q;
    lo_d    = lo_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    trial_s = {rem_q, lo_q[31]};
    diff_s  = trial_s - {1'b0, dvs_q};
    if (start_i) begin
      rem_d = {1'b0, dividend_i[62:32]};
      lo_d  = dividend_i[31:0];
      quo_d = 32'd0;
      dvs_d = divisor_i;
      cnt_d = 6'(DIV_CYCLES);
    end else if (cnt_q != 6'd0) begin
      if (!diff_s[32]) begin
        rem_d = diff_s[31:0];
        quo_d = {quo_q[30:0], 1'b1};
      end else begin
        rem_d = trial_s[31:0];
        quo_d = {quo_q[30:0], 1'b0};
      end
      lo_d  = {lo_q[30:0], 1'b0};
      cnt_d = cnt_q - 6'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Divider registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem_q <= 32'd0;
      lo_q  <= 32'd0;
      quo_q <= 32'd0;
      dvs_q <= 32'd0;
      cnt_q <= 6'd0;
    end else begin
      rem_q <= rem_d;
      lo_q  <= lo_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign busy_o     = (cnt_q != 6'd0);
  assign quotient_o = quo_q;

endmodule

// File: rtl/stepper_ctrl.sv
// -----------------------------------------------------------------------------
// stepper_ctrl
// Timed point-to-point motion generator for one stepper axis. A move request
// (absolute or relative target, duration in clocks) is turned into a constant
// velocity by a serial divider, then a fixed-point accumulator emits one step
// pulse per whole-step crossing; a last-clock fixup lands exactly on target.
// Optional feature macro: STEPPER_VELOCITY_CMD_EN -- a start with
// target_time == 0 enters an open-ended jog at target_velocity.
// Ports:
//   clk, reset              : clock, asynchronous active-low reset
//   start, relative         : move request (idle only) and relative-target flag
//   target_time             : move duration in clocks
//   target_position         : signed target or offset
//   target_velocity         : signed jog velocity (jog build only)
//   set_position, data_in   : load position while idle
//   position, velocity      : current position (steps), velocity (2^-31 step/clk)
//   acc                     : velocity change applied at the last move start
//   end_position            : absolute target of current/last move
//   end_velocity            : velocity of current/last move
//   step, dir, done         : step pulse, direction (1 = positive), done pulse
// -----------------------------------------------------------------------------
module stepper_ctrl
  import stepper_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        relative,
  input  logic [31:0] target_time,
  input  logic [31:0] target_position,
  input  logic [31:0] target_velocity,
  input  logic        set_position,
  input  logic [31:0] data_in,
  output logic [31:0] position,
  output logic [31:0] velocity,
  output logic [31:0] acc,
  output logic [31:0] end_position,
  output logic [31:0] end_velocity,
  output logic        step,
  output logic        dir,
  output logic        done
);

  state_e state_q, state_d;

  logic [31:0]          pos_q, pos_d;
  logic [31:0]          vel_q, vel_d;
  logic [31:0]          acc_q, acc_d;
  logic [31:0]          end_pos_q, end_pos_d;
  logic [31:0]          end_vel_q, end_vel_d;
  logic [31:0]          dp_q, dp_d;
  logic [31:0]          t_q, t_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [FRAC_BITS-1:0] frac_q, frac_d;
  logic [FRAC_BITS-1:0] vmag_q, vmag_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic                 done_q, done_d;

  logic                 load_pos_s;
  logic                 accept_s;
  logic                 jog_start_s;
  logic [31:0]          jog_vel_s;
  logic [FRAC_BITS-1:0] jog_mag_s;
  logic [31:0]          tgt_s;
  logic [31:0]          dp_s;
  logic [31:0]          dp_new_abs_s;
  logic [31:0]          dp_abs_s;
  logic [62:0]          dividend_s;
  logic                 div_busy_s;
  logic [31:0]          quotient_s;
  logic                 unused_q_s;
  logic                 clamp_s;
  logic                 degen_s;
  logic [FRAC_BITS-1:0] v_mag_s;
  logic [31:0]          v_signed_s;
  logic [31:0]          sum_s;
  logic                 carry_s;
  logic [31:0]          remain_s;
  logic                 fixup_s;

`ifdef STEPPER_VELOCITY_CMD_EN
  assign jog_start_s = (target_time == 32'd0);
  assign jog_vel_s   = target_velocity;
`else
  logic unused_tv_s;
  assign jog_start_s = 1'b0;
  assign jog_vel_s   = 32'd0;
  assign unused_tv_s = ^target_velocity;
`endif

  // A jog velocity of exactly -2^31 has no 31-bit magnitude and jogs at zero.
  assign jog_mag_s = jog_vel_s[31] ? (31'd0 - jog_vel_s[30:0]) : jog_vel_s[30:0];

  // set_position has priority over start in IDLE; JOG accepts start like IDLE.
  assign load_pos_s = (state_q == IDLE) && set_position;
  assign accept_s   = start && (((state_q == IDLE) && !set_position) || (state_q == JOG));

  assign tgt_s        = relative ? (pos_q + target_position) : target_position;
  assign dp_s         = tgt_s - pos_q;
  assign dp_new_abs_s = abs32(dp_s);
  assign dividend_s   = {dp_new_abs_s, {FRAC_BITS{1'b0}}};

  stepper_div u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (accept_s),
    .dividend_i (dividend_s),
    .divisor_i  (target_time),
    .busy_o     (div_busy_s),
    .quotient_o (quotient_s)
  );

  assign unused_q_s = quotient_s[31];

  assign dp_abs_s   = abs32(dp_q);
  assign clamp_s    = (dp_abs_s >= t_q);
  assign degen_s    = (t_q == 32'd0) || (dp_q == 32'd0);
  assign v_mag_s    = clamp_s ? V_MAX : quotient_s[FRAC_BITS-1:0];
  assign v_signed_s = dir_q ? {1'b0, v_mag_s} : (32'd0 - {1'b0, v_mag_s});

  // Both addends are below one step, so at most one step carries per clock.
  assign sum_s   = {1'b0, frac_q} + {1'b0, vmag_q};
  assign carry_s = sum_s[FRAC_BITS];

  assign remain_s = end_pos_q - pos_q;
  assign fixup_s  = dir_q ? (remain_s == 32'd1) : (remain_s == 32'hFFFF_FFFF);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, JOG: begin
        if (accept_s) begin
          state_d = jog_start_s ? JOG : CALC;
        end else begin
          state_d = state_q;
        end
      end
      CALC: begin
        if (degen_s) begin
          state_d = IDLE;
        end else if (!div_busy_s) begin
          state_d = MOVE;
        end else begin
          state_d = CALC;
        end
      end
      MOVE: begin
        if (cnt_q == t_q) begin
          state_d = IDLE;
        end else begin
          state_d = MOVE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath / output next values.
  always_comb begin
    pos_d     = pos_q;
    vel_d     = vel_q;
    acc_d     = acc_q;
    end_pos_d = end_pos_q;
    end_vel_d = end_vel_q;
    dp_d      = dp_q;
    t_d       = t_q;
    cnt_d     = cnt_q;
    frac_d    = frac_q;
    vmag_d    = vmag_q;
    dir_d     = dir_q;
    step_d    = 1'b0;
    done_d    = 1'b0;
    if (load_pos_s) begin
      pos_d  = data_in;
      frac_d = HALF_STEP;
    end else if (accept_s) begin
      end_pos_d = tgt_s;
      dp_d      = dp_s;
      t_d       = target_time;
      cnt_d     = 32'd0;
      frac_d    = HALF_STEP;
      if (jog_start_s) begin
        vel_d     = jog_vel_s;
        end_vel_d = jog_vel_s;
        vmag_d    = jog_mag_s;
        dir_d     = ~jog_vel_s[31];
      end else begin
        dir_d = ~dp_s[31];
      end
    end else begin
      case (state_q)
        CALC: begin
          if (degen_s) begin
            acc_d     = 32'd0 - vel_q;
            vel_d     = 32'd0;
            end_vel_d = 32'd0;
            vmag_d    = '0;
            done_d    = 1'b1;
          end else if (!div_busy_s) begin
            acc_d     = v_signed_s - vel_q;
            vel_d     = v_signed_s;
            end_vel_d = v_signed_s;
            vmag_d    = v_mag_s;
          end else begin
            vel_d = vel_q;
          end
        end
        MOVE: begin
          if (cnt_q != t_q) begin
            frac_d = sum_s[FRAC_BITS-1:0];
            cnt_d  = cnt_q + 32'd1;
            if (carry_s) begin
              step_d = 1'b1;
              pos_d  = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
            end else begin
              step_d = 1'b0;
            end
          end else begin
            // Closing clock: land the last step if rounding left one short.
            if (fixup_s) begin
              step_d = 1'b1;
              pos_d  = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
            end else begin
              step_d = 1'b0;
            end
            vel_d  = 32'd0;
            vmag_d = '0;
            done_d = 1'b1;
          end
        end
        JOG: begin
          frac_d = sum_s[FRAC_BITS-1:0];
          if (carry_s) begin
            step_d = 1'b1;
            pos_d  = dir_q ? (pos_q + 32'd1) : (pos_q - 32'd1);
          end else begin
            step_d = 1'b0;
          end
        end
        default: begin
          step_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath / output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos_q     <= 32'd0;
      vel_q     <= 32'd0;
      acc_q     <= 32'd0;
      end_pos_q <= 32'd0;
      end_vel_q <= 32'd0;
      dp_q      <= 32'd0;
      t_q       <= 32'd0;
      cnt_q     <= 32'd0;
      frac_q    <= HALF_STEP;
      vmag_q    <= '0;
      step_q    <= 1'b0;
      dir_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pos_q     <= pos_d;
      vel_q     <= vel_d;
      acc_q     <= acc_d;
      end_pos_q <= end_pos_d;
      end_vel_q <= end_vel_d;
      dp_q      <= dp_d;
      t_q       <= t_d;
      cnt_q     <= cnt_d;
      frac_q    <= frac_d;
      vmag_q    <= vmag_d;
      step_q    <= step_d;
      dir_q     <= dir_d;
      done_q    <= done_d;
    end
  end

  assign position     = pos_q;
  assign velocity     = vel_q;
  assign acc          = acc_q;
  assign end_position = end_pos_q;
  assign end_velocity = end_vel_q;
  assign step         = step_q;
  assign dir          = dir_q;
  assign done         = done_q;

endmodule

// File: tb/tb_stepper_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stepper_ctrl
// Self-checking bench for stepper_ctrl: directed moves plus randomized moves,
// each compared with a reference computed from the motion rules in plain
// arithmetic (velocity by division, step count from the accumulated distance).
// -----------------------------------------------------------------------------
module tb_stepper_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        relative = 1'b0;
  logic [31:0] target_time = 32'd0;
  logic [31:0] target_position = 32'd0;
  logic [31:0] target_velocity = 32'd0;
  logic        set_position = 1'b0;
  logic [31:0] data_in = 32'd0;
  logic [31:0] position, velocity, acc, end_position, end_velocity;
  logic        step, dir, done;

  int errors = 0;
  int checks = 0;
  int mpos   = 0;

  always #5 clk = ~clk;

  stepper_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .relative        (relative),
    .target_time     (target_time),
    .target_position (target_position),
    .target_velocity (target_velocity),
    .set_position    (set_position),
    .data_in         (data_in),
    .position        (position),
    .velocity        (velocity),
    .acc             (acc),
    .end_position    (end_position),
    .end_velocity    (end_velocity),
    .step            (step),
    .dir             (dir),
    .done            (done)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one move at the current negedge and follow it to done.
  task automatic do_move(input bit rel, input int tp, input int unsigned t, input bit poke);
    int tgt, dp, exp_k, k_done, steps, dir_err, sv;
    longint unsigned mag, v, n;
    bit degen, pos_dir;
    tgt     = rel ? (mpos + tp) : tp;
    dp      = tgt - mpos;
    pos_dir = (dp >= 0);
    mag     = (dp < 0) ? longint'(-dp) : longint'(dp);
    degen   = (t == 0) || (dp == 0);
    if (degen) begin
      v = 0; n = 0; exp_k = 1;
    end else begin
      if (mag >= t) v = 64'h7FFF_FFFF;
      else          v = (mag << 31) / t;
      n = ((64'd1 << 30) + longint'(t) * v) >> 31;
      if (n > mag) n = mag;
      if (mag - n == 1) n = n + 1;
      exp_k = int'(t) + 34;
    end
    sv = pos_dir ? int'(v) : -int'(v);

    start = 1'b1; relative = rel; target_position = tp; target_time = t;
    @(negedge clk);
    start = 1'b0; relative = 1'b0;
    check("end_position", $signed(end_position), tgt);
    check("dir_accept", dir, pos_dir);

    k_done = -1; steps = 0; dir_err = 0;
    for (int i = 1; i <= exp_k + 40; i++) begin
      @(negedge clk);
      if (poke && i == 50) begin
        start = 1'b1; relative = 1'b0; target_position = 32'h4000_0000; target_time = 32'd5;
        set_position = 1'b1; data_in = 32'd777;
      end else begin
        start = 1'b0; set_position = 1'b0;
      end
      if (step) steps++;
      if (dir !== pos_dir) dir_err++;
      if (i == 34 && !degen) check("velocity_move", $signed(velocity), sv);
      if (done) begin
        k_done = i;
        break;
      end
    end
    start = 1'b0; set_position = 1'b0;

    mpos = pos_dir ? (mpos + int'(n)) : (mpos - int'(n));
    check("done_cycle", k_done, exp_k);
    check("step_count", steps, n);
    check("dir_hold", dir_err, 0);
    check("position", $signed(position), mpos);
    check("velocity_idle", $signed(velocity), 0);
    if (!degen) begin
      check("end_velocity", $signed(end_velocity), sv);
      check("acc", $signed(acc), sv);
    end
  endtask

  initial begin
    int off, busy_seen, sel;
    int unsigned tt;
    bit rel;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_position", position, 0);
    check("rst_velocity", velocity, 0);
    check("rst_step", step, 0);
    check("rst_done", done, 0);
    check("rst_dir", dir, 0);
    check("rst_end_position", end_position, 0);
    reset = 1'b1;
    @(negedge clk);

    // Directed moves, back-to-back so each start lands in the done cycle
    do_move(1'b0, 5, 2000, 1'b0);
    do_move(1'b0, -15, 5000, 1'b1);
    check("end_vel_negative", end_velocity[31], 1);

    set_position = 1'b1; data_in = 32'(-10);
    @(negedge clk);
    set_position = 1'b0;
    check("setpos_neg_position", $signed(position), -10);
    check("setpos_neg_nostep", step, 0);
    mpos = -10;

    do_move(1'b1, 10, 1000, 1'b1);
    check("rel_end_position", $signed(end_position), 0);

    set_position = 1'b1; data_in = 32'd100;
    @(negedge clk);
    set_position = 1'b0;
    check("setpos_position", $signed(position), 100);
    check("setpos_nostep", step, 0);
    mpos = 100;

    // start coinciding with set_position is dropped
    start = 1'b1; set_position = 1'b1; data_in = 32'd42;
    relative = 1'b0; target_position = 32'd500; target_time = 32'd100;
    @(negedge clk);
    start = 1'b0; set_position = 1'b0;
    check("coincide_position", $signed(position), 42);
    mpos = 42;
    busy_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || step) busy_seen++;
    end
    check("coincide_no_move", busy_seen, 0);
    check("coincide_position_hold", $signed(position), 42);

    // Degenerate and clamped moves
    do_move(1'b0, mpos, 50, 1'b0);
    do_move(1'b1, 7, 0, 1'b0);
    do_move(1'b1, 10, 3, 1'b0);
    do_move(1'b1, -6, 5, 1'b0);
    do_move(1'b1, 5, 5, 1'b0);

    // Randomized moves
    for (int r = 0; r < 14; r++) begin
      rel = 1'($urandom_range(0, 1));
      off = int'($urandom_range(0, 1200)) - 600;
      sel = int'($urandom_range(0, 7));
      tt  = (sel < 3) ? $urandom_range(1, 20) : $urandom_range(21, 2500);
      if (sel == 3) tt = 0;
      if (sel == 4) off = 0;
      do_move(rel, rel ? off : (mpos + off), tt, (tt > 100));
    end

    // Reset in the middle of a move
    start = 1'b1; relative = 1'b0; target_position = mpos + 300; target_time = 32'd3000;
    @(negedge clk);
    start = 1'b0;
    repeat (200) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_position", position, 0);
    check("abort_velocity", velocity, 0);
    check("abort_step", step, 0);
    check("abort_done", done, 0);
    check("abort_dir", dir, 0);
    check("abort_end_position", end_position, 0);
    @(negedge clk);
    reset = 1'b1;
    mpos = 0;
    @(negedge clk);
    do_move(1'b0, 3, 100, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
